bip_pc_seq: RTL and testbench

Parametrised program-counter sequencer for the BIP processor. Adds synchronous reset, an explicit IDLE/RUN/HALT run-control FSM, edge-detected start, stall, and a wrap-around flag to the instruction-address generator. Sits between the control unit (WrPC, halt, stall) and the program memory address input (Addr).

---
 rtl/bip_pc_pkg.sv | 23 ++
 rtl/bip_pc_ret_stack.sv | 49 ++++
 rtl/bip_pc_seq.sv | 140 ++++++++++++++
 tb/tb_bip_pc_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bip_pc_pkg.sv
// BIP program-counter shared types: run-control state encoding, default widths, increment helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package bip_pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int DEF_AB          = 11;
    localparam int DEF_RESET_ADDR  = 0;
    localparam int DEF_INC         = 1;
    localparam int DEF_STACK_DEPTH = 4;

    // 33-bit sum of two zero-extended 32-bit operands; the caller splits it at
    // its own address width, and any set bit above that width is the wrap carry.
    function automatic logic [32:0] pc_add(input logic [31:0] a, input logic [31:0] inc);
        return {1'b0, a} + {1'b0, inc};
    endfunction

endpackage

// File: rtl/bip_pc_ret_stack.sv
// Return-address LIFO for call/ret; push when full drops the entry, pop when empty changes nothing.
// Latency: push/pop take effect on the next clk edge; top_dat is combinational from the pointer.
// Backpressure: none; overflow/underflow attempts set a sticky err flag cleared only by rst.
module bip_pc_ret_stack #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_dat,
    output logic [W-1:0] top_dat,
    output logic         full,
    output logic         empty,
    output logic         err
);
    localparam int CW = $clog2(DEPTH + 1);

    // Sized to the full pointer range so every pointer value is a legal index.
    logic [W-1:0]  mem [0:(2**CW)-1];
    logic [CW-1:0] cnt;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign top_dat = mem[cnt - CW'(1)];

    // Entry storage: pop has priority, so a simultaneous push is discarded.
    always_ff @(posedge clk) begin
        if (push && !pop && !full) begin
            mem[cnt] <= push_dat;
        end
    end

    // Occupancy and sticky error tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (pop) begin
            if (empty) err <= 1'b1;
            else       cnt <= cnt - CW'(1);
        end else if (push) begin
            if (full)  err <= 1'b1;
            else       cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bip_pc_seq.sv
// BIP program-counter sequencer with IDLE/RUN/HALT run control; optional return stack under BIP_PC_CALL_STACK_EN.
// Latency: one clk from any input to Addr/running/done/pc_wrap (all registered).
// Backpressure: stall holds Addr for the cycle; halt parks the FSM until a new start edge.
module bip_pc_seq
    import bip_pc_pkg::*;
#(
    parameter int AB          = DEF_AB,
    parameter int RESET_ADDR  = DEF_RESET_ADDR,
    parameter int INC         = DEF_INC,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_bip,
    input  logic          WrPC,
    input  logic [AB-1:0] address_bus,
    input  logic          stall,
    input  logic          halt,
    output logic [AB-1:0] Addr,
    output logic          running,
    output logic          done,
    output logic          pc_wrap
`ifdef BIP_PC_CALL_STACK_EN
    ,
    input  logic          call,
    input  logic          ret,
    output logic          stack_err
`endif
);

    // Elaboration-time parameter sanity.
    if (AB < 1 || AB > 32)                       $error("AB out of range");
    if (RESET_ADDR < 0 || RESET_ADDR >= 2**AB)   $error("RESET_ADDR does not fit in AB bits");
    if (INC < 1 || INC >= 2**AB)                 $error("INC out of range");
    if (STACK_DEPTH < 2)                         $error("STACK_DEPTH must be at least 2");

    localparam logic [AB-1:0] RST_A = AB'(RESET_ADDR);

    pc_state_t     state;
    logic          start_q;
    logic          start_pulse;
    logic [32:0]   sum;
    logic [AB-1:0] addr_inc;
    logic          inc_carry;

    assign start_pulse = start_bip & ~start_q;
    assign sum         = pc_add(32'(Addr), 32'(INC));
    assign addr_inc    = sum[AB-1:0];
    assign inc_carry   = |sum[32:AB];

`ifdef BIP_PC_CALL_STACK_EN
    logic          advance;
    logic          do_pop;
    logic          do_push;
    logic [AB-1:0] stk_top;
    logic          stk_full;
    logic          stk_empty;

    // A RUN cycle that is neither halted nor stalled may change Addr.
    assign advance = (state == RUN) && !halt && !stall;
    assign do_pop  = advance && ret;
    assign do_push = advance && call && !ret;

    bip_pc_ret_stack #(
        .W     (AB),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (do_push),
        .pop      (do_pop),
        .push_dat (addr_inc),
        .top_dat  (stk_top),
        .full     (stk_full),
        .empty    (stk_empty),
        .err      (stack_err)
    );
`endif

    // Run-control FSM, start edge detector and address register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            Addr    <= RST_A;
            running <= 1'b0;
            done    <= 1'b0;
            pc_wrap <= 1'b0;
            // Track start_bip even in reset so a level held across reset
            // cannot masquerade as a fresh edge once reset drops.
            start_q <= start_bip;
        end else begin
            start_q <= start_bip;
            pc_wrap <= 1'b0;
            case (state)
                IDLE: begin
                    Addr <= RST_A;
                    if (start_pulse) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state   <= HALT;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (stall) begin
                        Addr <= Addr;
`ifdef BIP_PC_CALL_STACK_EN
                    end else if (ret) begin
                        if (!stk_empty) Addr <= stk_top;
                    end else if (call) begin
                        Addr <= address_bus;
`endif
                    end else if (WrPC) begin
                        Addr <= address_bus;
                    end else begin
                        Addr    <= addr_inc;
                        pc_wrap <= inc_carry;
                    end
                end
                HALT: begin
                    if (start_pulse) begin
                        state   <= RUN;
                        Addr    <= RST_A;
                        running <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    Addr    <= RST_A;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip_pc_seq.sv
// Directed self-checking bench for bip_pc_seq: vector table on an AB=11 instance, wrap sequence on AB=4.
// Latency: each vector is applied at negedge and its result checked at the following negedge.
// Backpressure: n/a.
module tb_bip_pc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_bip, wrpc, stall, halt;
    logic [10:0] bus;
    logic [10:0] addr;
    logic        running, done, pc_wrap;

    logic        w_start, w_wrpc, w_stall, w_halt;
    logic [3:0]  w_bus;
    logic [3:0]  w_addr;
    logic        w_running, w_done, w_wrap;

`ifdef BIP_PC_CALL_STACK_EN
    logic        call, ret, stack_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bip_pc_seq #(.AB(11)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start_bip   (start_bip),
        .WrPC        (wrpc),
        .address_bus (bus),
        .stall       (stall),
        .halt        (halt),
        .Addr        (addr),
        .running     (running),
        .done        (done),
        .pc_wrap     (pc_wrap)
`ifdef BIP_PC_CALL_STACK_EN
        ,
        .call        (call),
        .ret         (ret),
        .stack_err   (stack_err)
`endif
    );

    bip_pc_seq #(.AB(4)) u_w (
        .clk         (clk),
        .rst         (rst),
        .start_bip   (w_start),
        .WrPC        (w_wrpc),
        .address_bus (w_bus),
        .stall       (w_stall),
        .halt        (w_halt),
        .Addr        (w_addr),
        .running     (w_running),
        .done        (w_done),
        .pc_wrap     (w_wrap)
`ifdef BIP_PC_CALL_STACK_EN
        ,
        .call        (1'b0),
        .ret         (1'b0),
        .stack_err   ()
`endif
    );

    typedef struct packed {
        logic        rst;
        logic        start;
        logic        wrpc;
        logic [10:0] bus;
        logic        stall;
        logic        halt;
        logic [10:0] e_addr;
        logic        e_run;
        logic        e_done;
        logic        e_wrap;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic wp, input int b,
                       input logic st, input logic h, input int a,
                       input logic er, input logic ed, input logic ew);
        vec_t v;
        v.rst = r; v.start = s; v.wrpc = wp; v.bus = 11'(b);
        v.stall = st; v.halt = h; v.e_addr = 11'(a);
        v.e_run = er; v.e_done = ed; v.e_wrap = ew;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start_bip = 1'b0; wrpc = 1'b0; stall = 1'b0; halt = 1'b0; bus = '0;
        w_start = 1'b0; w_wrpc = 1'b0; w_stall = 1'b0; w_halt = 1'b0; w_bus = '0;
`ifdef BIP_PC_CALL_STACK_EN
        call = 1'b0; ret = 1'b0;
`endif
        //   rst st wp bus    stl hlt addr   run done wrap
        add(1, 0, 0, 0,     0, 0, 0,     0, 0, 0);  // reset
        add(1, 0, 0, 0,     0, 0, 0,     0, 0, 0);
        add(0, 1, 0, 0,     0, 0, 0,     1, 0, 0);  // start edge -> RUN at 0
        add(0, 1, 0, 0,     0, 0, 1,     1, 0, 0);  // held start: single entry
        add(0, 1, 0, 0,     0, 0, 2,     1, 0, 0);
        add(0, 1, 0, 0,     0, 0, 3,     1, 0, 0);
        add(0, 1, 0, 0,     0, 0, 4,     1, 0, 0);
        add(0, 0, 0, 0,     0, 0, 5,     1, 0, 0);
        add(0, 0, 1, 'h3F0, 0, 0, 'h3F0, 1, 0, 0);  // jump
        add(0, 0, 0, 0,     1, 0, 'h3F0, 1, 0, 0);  // stall x2
        add(0, 0, 1, 5,     1, 0, 'h3F0, 1, 0, 0);  // stall beats WrPC
        add(0, 0, 0, 0,     0, 0, 'h3F1, 1, 0, 0);
        add(0, 0, 1, 20,    0, 0, 20,    1, 0, 0);
        add(0, 0, 1, 100,   0, 1, 20,    0, 1, 0);  // halt beats WrPC
        add(0, 0, 0, 0,     0, 0, 20,    0, 1, 0);  // frozen in HALT
        add(0, 1, 0, 0,     0, 0, 0,     1, 0, 0);  // restart from HALT
        add(0, 1, 0, 0,     0, 0, 1,     1, 0, 0);
        add(0, 1, 1, 7,     0, 0, 7,     1, 0, 0);
        add(1, 1, 1, 9,     0, 0, 0,     0, 0, 0);  // reset mid-run, start held
        add(0, 1, 0, 0,     0, 0, 0,     0, 0, 0);  // no restart while held
        add(0, 1, 1, 9,     1, 1, 0,     0, 0, 0);  // IDLE ignores controls
        add(0, 0, 0, 0,     0, 0, 0,     0, 0, 0);
        add(0, 1, 0, 0,     0, 0, 0,     1, 0, 0);  // fresh edge starts
        add(0, 1, 0, 0,     0, 1, 0,     0, 1, 0);  // halt at 0
        add(0, 1, 0, 0,     0, 0, 0,     0, 1, 0);  // held start does not restart
        add(0, 0, 0, 0,     0, 0, 0,     0, 1, 0);
        add(0, 1, 0, 0,     0, 0, 0,     1, 0, 0);  // edge restarts
        add(0, 0, 0, 0,     0, 0, 1,     1, 0, 0);
        add(0, 1, 0, 0,     0, 0, 2,     1, 0, 0);  // edge in RUN ignored

        @(negedge clk);
        foreach (tbl[i]) begin
            rst = tbl[i].rst; start_bip = tbl[i].start; wrpc = tbl[i].wrpc;
            bus = tbl[i].bus; stall = tbl[i].stall; halt = tbl[i].halt;
            tick();
            chk($sformatf("v%0d.addr", i), int'(addr),    int'(tbl[i].e_addr));
            chk($sformatf("v%0d.run", i),  int'(running), int'(tbl[i].e_run));
            chk($sformatf("v%0d.done", i), int'(done),    int'(tbl[i].e_done));
            chk($sformatf("v%0d.wrap", i), int'(pc_wrap), int'(tbl[i].e_wrap));
        end

        // Wrap on the 4-bit instance.
        start_bip = 1'b0; wrpc = 1'b0; stall = 1'b0; halt = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        w_start = 1'b1; tick(); w_start = 1'b0;
        chk("w.start_addr", int'(w_addr), 0);
        chk("w.start_run", int'(w_running), 1);
        w_wrpc = 1'b1; w_bus = 4'd15; tick(); w_wrpc = 1'b0;
        chk("w.jump15", int'(w_addr), 15);
        chk("w.nowrap_on_jump", int'(w_wrap), 0);
        tick();
        chk("w.wrap_addr", int'(w_addr), 0);
        chk("w.wrap_pulse", int'(w_wrap), 1);
        tick();
        chk("w.after_addr", int'(w_addr), 1);
        chk("w.wrap_cleared", int'(w_wrap), 0);

`ifdef BIP_PC_CALL_STACK_EN
        rst = 1'b1; tick(); rst = 1'b0;
        start_bip = 1'b1; tick(); start_bip = 1'b0;
        tick(); tick(); tick();
        chk("s.at3", int'(addr), 3);
        call = 1'b1; bus = 11'd50; tick(); call = 1'b0;
        chk("s.call50", int'(addr), 50);
        ret = 1'b1; tick(); ret = 1'b0;
        chk("s.ret4", int'(addr), 4);
        for (int k = 0; k < 4; k++) begin
            call = 1'b1; bus = 11'(100 + k); tick();
            chk($sformatf("s.nest%0d", k), int'(addr), 100 + k);
            chk($sformatf("s.noerr%0d", k), int'(stack_err), 0);
        end
        bus = 11'd104; tick(); call = 1'b0;
        chk("s.overflow_jump", int'(addr), 104);
        chk("s.overflow_err", int'(stack_err), 1);
        ret = 1'b1; tick(); ret = 1'b0;
        chk("s.ret_top", int'(addr), 103);
        chk("s.err_sticky", int'(stack_err), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule
